// File: rtl/phoenix_vc_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : phoenix_vc_buffer_if
// Description : Flit ingress, routing request and crossbar handshake bundle
//               of the multi-VC router input buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface phoenix_vc_buffer_if #(
   parameter int FLIT_W = 16,
   parameter int NUM_VC = 2
);
   localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   logic                     rx;
   logic [VC_W-1:0]          rx_vc;
   logic [FLIT_W-1:0]        data_in;
   logic [NUM_VC-1:0]        credit_o;
   logic [NUM_VC-1:0]        overflow;
   logic [NUM_VC-1:0]        h;
   logic [NUM_VC-1:0]        ack_h;
   logic [NUM_VC-1:0]        data_av;
   logic [NUM_VC-1:0]        data_ack;
   logic [NUM_VC-1:0]        sender;
   logic [NUM_VC*FLIT_W-1:0] data;

   modport slave (
      input  rx, rx_vc, data_in, ack_h, data_ack,
      output credit_o, overflow, h, data_av, sender, data
   );

   modport master (
      output rx, rx_vc, data_in, ack_h, data_ack,
      input  credit_o, overflow, h, data_av, sender, data
   );
endinterface
`default_nettype wire

// File: rtl/phoenix_vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : phoenix_vc_buffer
// Description : Router input buffer with one FIFO and one packet FSM per VC.
// Revision    : 1.0 - initial release
// ============================================================================
module phoenix_vc_buffer #(
   parameter int FLIT_W = 16,
   parameter int DEPTH  = 4,
   parameter int NUM_VC = 2
) (
   input  logic               clock,
   input  logic               reset,
   phoenix_vc_buffer_if.slave vc_if
);
   localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;
   typedef enum logic [1:0] {PH_HDR = 2'd0, PH_SIZE = 2'd1, PH_PAY = 2'd2} phase_t;

   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic                     w_bad_vc;
   logic [NUM_VC-1:0]        w_credit;
   logic [NUM_VC-1:0]        w_ovf;
   logic [NUM_VC-1:0]        w_h;
   logic [NUM_VC-1:0]        w_av;
   logic [NUM_VC-1:0]        w_sender;
   logic [NUM_VC*FLIT_W-1:0] w_data;

   // Out-of-range VC selects are charged to the last VC's overflow flag
   assign w_bad_vc = vc_if.rx & ({1'b0, vc_if.rx_vc} >= (VC_W + 1)'(NUM_VC));

   generate
      for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
         logic [FLIT_W-1:0] r_mem [DEPTH];
         logic [PTR_W-1:0]  r_rd_ptr;
         logic [PTR_W-1:0]  r_wr_ptr;
         logic [CNT_W-1:0]  r_count;
         logic [FLIT_W-1:0] r_rem;
         logic [FLIT_W-1:0] w_rem_nxt;
         state_t            r_state;
         state_t            w_state_nxt;
         phase_t            r_phase;
         phase_t            w_phase_nxt;
         logic              r_ovf;
         logic [FLIT_W-1:0] w_head;
         logic              w_has_data;
         logic              w_full;
         logic              w_push;
         logic              w_av_v;
         logic              w_pop;
         logic              w_wr_en;
         logic              w_ovf_set;

         assign w_head     = r_mem[r_rd_ptr];
         assign w_has_data = (r_count != '0);
         assign w_full     = (r_count == c_FULL_CNT);
         assign w_push     = vc_if.rx & (vc_if.rx_vc == VC_W'(v));
         assign w_av_v     = (r_state == ST_SEND) & w_has_data;
         assign w_pop      = w_av_v & vc_if.data_ack[v];
         assign w_wr_en    = w_push & (~w_full | w_pop);
         assign w_ovf_set  = (w_push & w_full & ~w_pop) | ((v == NUM_VC - 1) && w_bad_vc);

         always_ff @(posedge clock) begin
            if (reset) begin
               r_rd_ptr <= '0;
               r_wr_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (w_wr_en) begin
                  r_mem[r_wr_ptr] <= vc_if.data_in;
                  r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
               end
               if (w_pop) begin
                  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
               end
               case ({w_wr_en, w_pop})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
            end
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               r_state <= ST_IDLE;
               r_phase <= PH_HDR;
               r_rem   <= '0;
               r_ovf   <= 1'b0;
            end else begin
               r_state <= w_state_nxt;
               r_phase <= w_phase_nxt;
               r_rem   <= w_rem_nxt;
               if (w_ovf_set) begin
                  r_ovf <= 1'b1;
               end
            end
         end

         always_comb begin
            w_state_nxt = r_state;
            w_phase_nxt = r_phase;
            w_rem_nxt   = r_rem;
            case (r_state)
               ST_IDLE: begin
                  if (vc_if.ack_h[v] & w_has_data) begin
                     w_state_nxt = ST_SEND;
                     w_phase_nxt = PH_HDR;
                  end
               end
               ST_SEND: begin
                  if (w_pop) begin
                     case (r_phase)
                        PH_HDR: w_phase_nxt = PH_SIZE;
                        PH_SIZE: begin
                           w_rem_nxt = w_head;
                           if (w_head == '0) begin
                              w_state_nxt = ST_IDLE;
                              w_phase_nxt = PH_HDR;
                           end else begin
                              w_phase_nxt = PH_PAY;
                           end
                        end
                        PH_PAY: begin
                           w_rem_nxt = r_rem - 1'b1;
                           if (r_rem == FLIT_W'(1)) begin
                              w_state_nxt = ST_IDLE;
                              w_phase_nxt = PH_HDR;
                           end
                        end
                        default: begin
                           w_state_nxt = ST_IDLE;
                           w_phase_nxt = PH_HDR;
                        end
                     endcase
                  end
               end
               default: w_state_nxt = ST_IDLE;
            endcase
         end

         assign w_credit[v]                 = ~w_full | w_pop;
         assign w_ovf[v]                    = r_ovf;
         assign w_h[v]                      = (r_state == ST_IDLE) & w_has_data;
         assign w_av[v]                     = w_av_v;
         assign w_sender[v]                 = (r_state == ST_SEND);
         assign w_data[v*FLIT_W +: FLIT_W]  = w_head;
      end
   endgenerate

   assign vc_if.credit_o = w_credit;
   assign vc_if.overflow = w_ovf;
   assign vc_if.h        = w_h;
   assign vc_if.data_av  = w_av;
   assign vc_if.sender   = w_sender;
   assign vc_if.data     = w_data;
endmodule
`default_nettype wire

// File: tb/tb_phoenix_vc_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_phoenix_vc_buffer
// Description : Directed vector bench for the multi-VC router input buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phoenix_vc_buffer;
   logic clock;
   logic reset;
   int   n_chk;
   int   n_fail;

   phoenix_vc_buffer_if #(.FLIT_W(16), .NUM_VC(2)) bus ();

   phoenix_vc_buffer #(.FLIT_W(16), .DEPTH(4), .NUM_VC(2)) dut (
      .clock (clock),
      .reset (reset),
      .vc_if (bus)
   );

   typedef struct {
      logic        rx;
      logic        vc;
      logic [15:0] din;
      logic [1:0]  ack_h;
      logic [1:0]  dack;
      logic [1:0]  e_credit;
      logic [1:0]  e_ovf;
      logic [1:0]  e_h;
      logic [1:0]  e_av;
      logic [1:0]  e_snd;
      logic [1:0]  chk_d;
      logic [15:0] e_d0;
      logic [15:0] e_d1;
   } vec_t;

   vec_t        vecs [12];
   logic [15:0] exp4 [2][3];
   logic [15:0] drain [4];
   int          idx [2];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rx, input logic vc, input logic [15:0] din,
                        input logic [1:0] ack_h, input logic [1:0] dack);
      @(negedge clock);
      bus.rx       = rx;
      bus.rx_vc    = vc;
      bus.data_in  = din;
      bus.ack_h    = ack_h;
      bus.data_ack = dack;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset        = 1'b1;
      bus.rx       = 1'b0;
      bus.ack_h    = 2'b00;
      bus.data_ack = 2'b00;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_credit"}, 32'(bus.credit_o), 32'h3);
      chk({tag, "_ovf"},    32'(bus.overflow), 32'h0);
      chk({tag, "_h"},      32'(bus.h),        32'h0);
      chk({tag, "_av"},     32'(bus.data_av),  32'h0);
      chk({tag, "_sender"}, 32'(bus.sender),   32'h0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      bus.rx = 1'b0; bus.rx_vc = 1'b0; bus.data_in = '0; bus.ack_h = '0; bus.data_ack = '0;

      // Packet on VC0 (hdr, size 2, 0xA, 0xB), then a size-0 packet on VC1 with a trailing header
      vecs[0]  = '{1'b1, 1'b0, 16'h0101, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 16'h0002, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 16'h0101, 16'h0000};
      vecs[2]  = '{1'b1, 1'b0, 16'h000A, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 16'h0101, 16'h0000};
      vecs[3]  = '{1'b1, 1'b0, 16'h000B, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 16'h0002, 16'h0000};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 16'h000A, 16'h0000};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 16'h000B, 16'h0000};
      vecs[6]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000};
      vecs[7]  = '{1'b1, 1'b1, 16'h0202, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000};
      vecs[8]  = '{1'b1, 1'b1, 16'h0000, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h0202};
      vecs[9]  = '{1'b1, 1'b1, 16'h0303, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 16'h0000, 16'h0202};
      vecs[10] = '{1'b0, 1'b1, 16'h0000, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 16'h0000, 16'h0000};
      vecs[11] = '{1'b0, 1'b1, 16'h0000, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h0303};

      exp4[0][0] = 16'h0100; exp4[0][1] = 16'h0001; exp4[0][2] = 16'h0A01;
      exp4[1][0] = 16'h0200; exp4[1][1] = 16'h0001; exp4[1][2] = 16'h0B01;
      drain[0] = 16'h0011; drain[1] = 16'h0012; drain[2] = 16'h0013; drain[3] = 16'h0020;

      repeat (2) @(negedge clock);
      reset = 1'b0;
      #2;
      chk_idle("reset");

      // Tests 1 and 2: table-driven
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rx, vecs[i].vc, vecs[i].din, vecs[i].ack_h, vecs[i].dack);
         #2;
         chk($sformatf("v%0d_credit", i), 32'(bus.credit_o), 32'(vecs[i].e_credit));
         chk($sformatf("v%0d_ovf", i),    32'(bus.overflow), 32'(vecs[i].e_ovf));
         chk($sformatf("v%0d_h", i),      32'(bus.h),        32'(vecs[i].e_h));
         chk($sformatf("v%0d_av", i),     32'(bus.data_av),  32'(vecs[i].e_av));
         chk($sformatf("v%0d_sender", i), 32'(bus.sender),   32'(vecs[i].e_snd));
         if (vecs[i].chk_d[0]) chk($sformatf("v%0d_data0", i), 32'(bus.data[15:0]),  32'(vecs[i].e_d0));
         if (vecs[i].chk_d[1]) chk($sformatf("v%0d_data1", i), 32'(bus.data[31:16]), 32'(vecs[i].e_d1));
      end

      // Test 3: fill, drop on full, then push+pop while full
      apply_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'(16'h0010 + i), 2'b00, 2'b00);
      drive(1'b1, 1'b0, 16'h0014, 2'b00, 2'b00);
      #2;
      chk("full_credit", 32'(bus.credit_o), 32'h2);
      chk("full_no_ovf_yet", 32'(bus.overflow), 32'h0);
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      chk("drop_ovf", 32'(bus.overflow), 32'h1);
      chk("drop_head", 32'(bus.data[15:0]), 32'h0010);
      chk("drop_credit", 32'(bus.credit_o), 32'h2);

      apply_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'(16'h0010 + i), 2'b00, 2'b00);
      drive(1'b0, 1'b0, 16'h0000, 2'b01, 2'b00);
      #2;
      chk("full_h", 32'(bus.h), 32'h1);
      drive(1'b1, 1'b0, 16'h0020, 2'b00, 2'b01);
      #2;
      chk("pushpop_credit", 32'(bus.credit_o), 32'h3);
      chk("pushpop_av", 32'(bus.data_av), 32'h1);
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      chk("pushpop_still_full", 32'(bus.credit_o), 32'h2);
      chk("pushpop_no_ovf", 32'(bus.overflow), 32'h0);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b01);
         #2;
         chk($sformatf("drain%0d_av", k), 32'(bus.data_av), 32'h1);
         chk($sformatf("drain%0d_data", k), 32'(bus.data[15:0]), 32'(drain[k]));
      end
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      chk("drained_credit", 32'(bus.credit_o), 32'h3);

      // Test 4: interleaved pushes, alternating data_ack, per-VC scoreboard
      apply_reset();
      idx[0] = 0;
      idx[1] = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         bus.rx       = (c < 6);
         bus.rx_vc    = c[0];
         bus.data_in  = (c < 6) ? exp4[c % 2][c / 2] : 16'h0000;
         bus.ack_h    = 2'b11;
         bus.data_ack = {~c[0], c[0]};
         #2;
         for (int v = 0; v < 2; v++) begin
            if (bus.data_av[v] && bus.data_ack[v]) begin
               if (idx[v] < 3) begin
                  chk($sformatf("ilv_vc%0d_flit%0d", v, idx[v]),
                      32'(bus.data[v*16 +: 16]), 32'(exp4[v][idx[v]]));
               end else begin
                  chk($sformatf("ilv_vc%0d_extra", v), 32'(idx[v]), 32'd2);
               end
               idx[v]++;
            end
         end
      end
      chk("ilv_vc0_count", 32'(idx[0]), 32'd3);
      chk("ilv_vc1_count", 32'(idx[1]), 32'd3);
      chk("ilv_sender_done", 32'(bus.sender), 32'h0);

      // Test 5: reset in the middle of the payload
      apply_reset();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 16'(16'h0030 + i), 2'b00, 2'b00);
      drive(1'b1, 1'b0, 16'h0500, 2'b00, 2'b00);
      drive(1'b1, 1'b0, 16'h0003, 2'b00, 2'b00);
      drive(1'b1, 1'b0, 16'h0001, 2'b00, 2'b00);
      drive(1'b1, 1'b0, 16'h0002, 2'b00, 2'b00);
      drive(1'b0, 1'b0, 16'h0000, 2'b01, 2'b00);
      drive(1'b1, 1'b0, 16'h0003, 2'b00, 2'b01);
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b01);
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      chk("midpay_sender", 32'(bus.sender), 32'h1);
      chk("midpay_data", 32'(bus.data[15:0]), 32'h0001);
      chk("midpay_ovf", 32'(bus.overflow), 32'h2);
      @(negedge clock);
      reset        = 1'b1;
      bus.data_ack = 2'b11;
      @(negedge clock);
      reset = 1'b0;
      #2;
      chk_idle("midpay_reset");
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         #2;
         chk($sformatf("postreset%0d_av", k), 32'(bus.data_av), 32'h0);
      end

      // Test 6: stray ack_h / data_ack on empty and idle VCs
      apply_reset();
      drive(1'b0, 1'b0, 16'h0000, 2'b01, 2'b01);
      #2;
      chk("stray_av", 32'(bus.data_av), 32'h0);
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      chk("stray_sender", 32'(bus.sender), 32'h0);
      drive(1'b1, 1'b0, 16'h0606, 2'b00, 2'b00);
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b01);
      #2;
      chk("idle_ack_h", 32'(bus.h), 32'h1);
      chk("idle_ack_av", 32'(bus.data_av), 32'h0);
      drive(1'b0, 1'b0, 16'h0000, 2'b00, 2'b01);
      #2;
      chk("idle_ack_no_pop", 32'(bus.data[15:0]), 32'h0606);
      chk("idle_ack_sender", 32'(bus.sender), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
